// File: rtl/qc_row_scheduler_if.sv
// Bus bundle between the LDPC row scheduler and its neighbours: row control,
// entry table, message buffer, mul_shift port and row results.
interface qc_row_scheduler_if #(
  parameter int unsigned MAX_ZC = 384,
  parameter int unsigned COL_W  = 7,
  parameter int unsigned ENT_W  = 5
);
  localparam int unsigned SZ_W = 9;

  logic              start;
  logic [SZ_W-1:0]   zc;
  logic [ENT_W-1:0]  num_entries;
  logic              entry_rd;
  logic [ENT_W-1:0]  entry_addr;
  logic [COL_W-1:0]  entry_col;
  logic [SZ_W-1:0]   entry_shift;
  logic              msg_rd;
  logic [COL_W-1:0]  msg_addr;
  logic [MAX_ZC-1:0] msg_data;
  logic [MAX_ZC-1:0] shift_block;
  logic [SZ_W-1:0]   shift_size;
  logic [SZ_W-1:0]   shift_factor;
  logic              shift_enable;
  logic [MAX_ZC-1:0] shift_result;
  logic              busy;
  logic              done;
  logic [MAX_ZC-1:0] acc_out;
  logic              err;

  // Scheduler side
  modport slave (
    input  start, zc, num_entries, entry_col, entry_shift, msg_data, shift_result,
    output entry_rd, entry_addr, msg_rd, msg_addr,
    output shift_block, shift_size, shift_factor, shift_enable,
    output busy, done, acc_out, err
  );

  // Environment side: row requester, tables, shifter
  modport master (
    output start, zc, num_entries, entry_col, entry_shift, msg_data, shift_result,
    input  entry_rd, entry_addr, msg_rd, msg_addr,
    input  shift_block, shift_size, shift_factor, shift_enable,
    input  busy, done, acc_out, err
  );
endinterface

// File: rtl/qc_row_scheduler.sv
// Walks one base-graph row's nonzero entries, fetches each message block,
// drives mul_shift and XOR-accumulates the shifted blocks into the row parity.
module qc_row_scheduler #(
  parameter int unsigned MAX_ZC      = 384,
  parameter int unsigned MAX_COLS    = 68,
  parameter int unsigned MAX_ENTRIES = 31
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  qc_row_scheduler_if.slave     bus
);
  localparam int unsigned COL_W = $clog2(MAX_COLS);
  localparam int unsigned ENT_W = $clog2(MAX_ENTRIES + 1);
  localparam int unsigned SZ_W  = 9;

  localparam logic [SZ_W-1:0] ZC_MIN = SZ_W'(2);
  localparam logic [SZ_W-1:0] ZC_MAX = SZ_W'(MAX_ZC);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ENT  = 3'd1;
  localparam logic [2:0] S_MSG  = 3'd2;
  localparam logic [2:0] S_SHF  = 3'd3;
  localparam logic [2:0] S_ACC  = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  logic [2:0]        r_state;
  logic [2:0]        w_next;
  logic [ENT_W-1:0]  r_idx;
  logic [ENT_W-1:0]  w_idx_nxt;
  logic [SZ_W-1:0]   r_zc;
  logic [ENT_W-1:0]  r_n;
  logic [SZ_W-1:0]   r_shift_q;
  logic              r_err;
  logic              r_busy;
  logic              r_done;
  logic [MAX_ZC-1:0] r_acc;
  logic              r_entry_rd;
  logic [ENT_W-1:0]  r_entry_addr;
  logic              r_msg_rd;
  logic              r_shift_en;
  logic [MAX_ZC-1:0] r_shift_block;
  logic [SZ_W-1:0]   r_shift_size;
  logic [SZ_W-1:0]   r_shift_factor;

  logic              w_legal;
  logic              w_last;
  logic              w_shift_ok;

  assign w_legal    = (bus.zc >= ZC_MIN) && (bus.zc <= ZC_MAX) &&
                      (bus.num_entries != '0);
  assign w_last     = (r_idx == (r_n - ENT_W'(1)));
  assign w_shift_ok = (bus.entry_shift < r_zc);

  // Next-state and entry index
  always_comb begin
    w_next    = r_state;
    w_idx_nxt = r_idx;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          if (w_legal) begin
            w_next    = S_ENT;
            w_idx_nxt = '0;
          end else begin
            w_next = S_DONE;
          end
        end
      end
      S_ENT: w_next = S_MSG;
      S_MSG: w_next = S_SHF;
      S_SHF: w_next = S_ACC;
      S_ACC: begin
        if (w_last) begin
          w_next = S_DONE;
        end else begin
          w_next    = S_ENT;
          w_idx_nxt = r_idx + ENT_W'(1);
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Strobes and shifter drive are registered off the next state so they
  // line up with the state they belong to.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_idx          <= '0;
      r_zc           <= '0;
      r_n            <= '0;
      r_shift_q      <= '0;
      r_err          <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_acc          <= '0;
      r_entry_rd     <= 1'b0;
      r_entry_addr   <= '0;
      r_msg_rd       <= 1'b0;
      r_shift_en     <= 1'b0;
      r_shift_block  <= '0;
      r_shift_size   <= '0;
      r_shift_factor <= '0;
    end else begin
      r_idx        <= w_idx_nxt;
      r_entry_rd   <= (w_next == S_ENT);
      r_entry_addr <= (w_next == S_ENT) ? w_idx_nxt : '0;
      r_msg_rd     <= (w_next == S_MSG);
      r_done       <= (w_next == S_DONE);

      if (w_next == S_ACC) begin
        r_shift_en     <= 1'b1;
        r_shift_block  <= bus.msg_data;
        r_shift_size   <= r_zc;
        r_shift_factor <= r_shift_q;
      end else begin
        r_shift_en     <= 1'b0;
        r_shift_block  <= '0;
        r_shift_size   <= '0;
        r_shift_factor <= '0;
      end

      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_acc <= '0;
            if (w_legal) begin
              r_zc   <= bus.zc;
              r_n    <= bus.num_entries;
              r_err  <= 1'b0;
              r_busy <= 1'b1;
            end else begin
              r_err  <= 1'b1;
            end
          end
        end
        // Out-of-range shift still accumulates, as an unshifted block
        S_MSG: begin
          r_shift_q <= w_shift_ok ? bus.entry_shift : '0;
          if (!w_shift_ok) r_err <= 1'b1;
        end
        S_ACC:  r_acc  <= r_acc ^ bus.shift_result;
        S_DONE: r_busy <= 1'b0;
        default: ;
      endcase
    end
  end

  assign bus.entry_rd     = r_entry_rd;
  assign bus.entry_addr   = r_entry_addr;
  assign bus.msg_rd       = r_msg_rd;
  // Column arrives from the entry table in the same cycle it is forwarded
  assign bus.msg_addr     = r_msg_rd ? bus.entry_col : '0;
  assign bus.shift_block  = r_shift_block;
  assign bus.shift_size   = r_shift_size;
  assign bus.shift_factor = r_shift_factor;
  assign bus.shift_enable = r_shift_en;
  assign bus.busy         = r_busy;
  assign bus.done         = r_done;
  assign bus.acc_out      = r_acc;
  assign bus.err          = r_err;

endmodule
